// File: rtl/inst_fetch_queue_if.sv
// Signal bundle between the fetch queue, the instruction RAM and the decode stage.
// The slave modport is the fetch queue's view. The master modport is the RAM/decode view.
interface inst_fetch_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 9
);
    logic                     imem_req;
    logic [ADDR_W-1:0]        imem_addr;
    logic [31:0]              imem_rdata;
    logic                     redirect;
    logic [ADDR_W-1:0]        redirect_pc;
    logic                     id_valid;
    logic                     id_ready;
    logic [31:0]              id_instr;
    logic [ADDR_W-1:0]        id_pc;
    logic [$clog2(DEPTH):0]   fq_count;

    modport slave (
        output imem_req, imem_addr, id_valid, id_instr, id_pc, fq_count,
        input  imem_rdata, redirect, redirect_pc, id_ready
    );

    modport master (
        input  imem_req, imem_addr, id_valid, id_instr, id_pc, fq_count,
        output imem_rdata, redirect, redirect_pc, id_ready
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// IF stage: owns the fetch PC and issues word reads against a credit-limited {pc, instr} FIFO.
// Decode reads the FIFO through a valid/ready handshake. Redirects flush all queued and in-flight work.
module inst_fetch_queue #(
    parameter int unsigned          DEPTH    = 4,
    parameter int unsigned          ADDR_W   = 9,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic                 clka,
    input  logic                 rst,
    inst_fetch_queue_if.slave    bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] fifo_pc_q    [DEPTH];
    logic [31:0]       fifo_instr_q [DEPTH];

    logic              req;
    logic              push;
    logic              pop;
    logic              head_vld;
    logic [CNT_W:0]    credit_used;

    always_comb begin
        pc_d        = pc_q;
        req_pc_d    = req_pc_q;
        inflight_d  = inflight_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        // An in-flight read reserves a slot, so a returning word always finds room.
        credit_used = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
        req         = !rst && !bus.redirect && (credit_used < (CNT_W + 1)'(DEPTH));
        head_vld    = (count_q != '0);
        push        = inflight_q && !bus.redirect;
        pop         = head_vld && bus.id_ready && !bus.redirect;

        if (bus.redirect) begin
            pc_d       = bus.redirect_pc & ~ADDR_W'(3);
            inflight_d = 1'b0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (req) begin
                pc_d     = pc_q + ADDR_W'(4);
                req_pc_d = pc_q;
            end
            inflight_d = req;
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the zero-bubble mask hides it while the FIFO is empty.
    always_ff @(posedge clka) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= req_pc_q;
            fifo_instr_q[wr_ptr_q] <= bus.imem_rdata;
        end
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.id_valid  = head_vld;
    assign bus.id_instr  = head_vld ? fifo_instr_q[rd_ptr_q] : 32'h0;
    assign bus.id_pc     = head_vld ? fifo_pc_q[rd_ptr_q] : '0;
    assign bus.fq_count  = count_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue. A stream model tracks the next PC that decode must accept.
// Hand-computed literals pin reset state, latency, backpressure, redirect, wrap and reset behaviour.
module tb_inst_fetch_queue;
    localparam int unsigned DEPTH    = 4;
    localparam int unsigned ADDR_W   = 9;
    localparam logic [8:0]  RESET_PC = 9'h000;

    logic clka = 1'b0;
    logic rst  = 1'b1;

    inst_fetch_queue_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) ifc ();

    inst_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clka (clka),
        .rst  (rst),
        .bus  (ifc.slave)
    );

    always #5 clka = ~clka;

    logic [7:0] ram [512];
    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] exp_pc = RESET_PC;

    // Word k of RAM is {k, k^5A, C3, k+11}; the k byte makes every word unique.
    function automatic logic [31:0] word_at(input logic [8:0] a);
        logic [7:0] k;
        k = {1'b0, a[8:2]};
        return {k, k ^ 8'h5A, 8'hC3, k + 8'h11};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!ifc.id_valid && n < 10) begin
            step();
            n++;
        end
        chk(nm, 32'(ifc.id_valid), 32'h1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            logic [31:0] w;
            w = word_at(9'(i * 4));
            ram[i*4]     = w[7:0];
            ram[i*4 + 1] = w[15:8];
            ram[i*4 + 2] = w[23:16];
            ram[i*4 + 3] = w[31:24];
        end
    end

    // Little-endian instruction RAM with one cycle of read latency.
    always @(posedge clka) begin
        if (ifc.imem_req)
            ifc.imem_rdata <= {ram[ifc.imem_addr + 9'd3], ram[ifc.imem_addr + 9'd2],
                               ram[ifc.imem_addr + 9'd1], ram[ifc.imem_addr]};
    end

    // Stream model: decode must see consecutive word addresses from the last reset/redirect target.
    always @(negedge clka) begin
        if (rst) begin
            exp_pc = RESET_PC;
        end else begin
            if (!ifc.id_valid) begin
                chk("bubble_instr", ifc.id_instr, 32'h0);
                chk("bubble_pc", 32'(ifc.id_pc), 32'h0);
            end
            chk("count_le_depth", 32'(ifc.fq_count <= 3'(DEPTH)), 32'h1);
            if (ifc.redirect) begin
                exp_pc = ifc.redirect_pc & 9'h1FC;
            end else if (ifc.id_valid && ifc.id_ready) begin
                chk("stream_pc", 32'(ifc.id_pc), 32'(exp_pc));
                chk("stream_instr", ifc.id_instr, word_at(exp_pc));
                exp_pc = exp_pc + 9'd4;
            end
        end
    end

    initial begin
        ifc.redirect    = 1'b0;
        ifc.redirect_pc = '0;
        ifc.id_ready    = 1'b0;
        repeat (2) @(posedge clka);
        #1;
        chk("rst_valid", 32'(ifc.id_valid), 32'h0);
        chk("rst_count", 32'(ifc.fq_count), 32'h0);
        chk("rst_req", 32'(ifc.imem_req), 32'h0);
        chk("rst_instr", ifc.id_instr, 32'h0);
        chk("rst_pc", 32'(ifc.id_pc), 32'h0);

        // 1: fetch from reset, one instruction per cycle
        ifc.id_ready = 1'b1;
        rst = 1'b0;
        #1;
        chk("t1_req0", 32'(ifc.imem_req), 32'h1);
        chk("t1_addr0", 32'(ifc.imem_addr), 32'h0);
        step();
        chk("t1_lat_valid0", 32'(ifc.id_valid), 32'h0);
        chk("t1_addr1", 32'(ifc.imem_addr), 32'h4);
        step();
        chk("t1_lat_valid1", 32'(ifc.id_valid), 32'h1);
        chk("t1_pc0", 32'(ifc.id_pc), 32'h0);
        chk("t1_w0", ifc.id_instr, 32'h005AC311);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("t1_valid", 32'(ifc.id_valid), 32'h1);
            chk("t1_pc", 32'(ifc.id_pc), 32'(i * 4));
            if (i == 1) chk("t1_w1", ifc.id_instr, 32'h015BC312);
        end

        // 2: backpressure fills the FIFO, then it drains without gaps
        ifc.id_ready = 1'b0;
        repeat (10) step();
        chk("t2_full", 32'(ifc.fq_count), 32'h4);
        chk("t2_req_low", 32'(ifc.imem_req), 32'h0);
        chk("t2_head", 32'(ifc.id_pc), 32'h1C);
        ifc.id_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("t2_drain_valid", 32'(ifc.id_valid), 32'h1);
        end

        // 3: redirect with count=3 and a read in flight
        ifc.id_ready = 1'b0;
        for (int i = 0; i < 6 && ifc.fq_count != 3'd3; i++) step();
        chk("t3_count3", 32'(ifc.fq_count), 32'h3);
        chk("t3_inflight", 32'(ifc.imem_req), 32'h0);
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 9'h040;
        step();
        ifc.redirect = 1'b0;
        #1;
        chk("t3_flush_count", 32'(ifc.fq_count), 32'h0);
        chk("t3_flush_valid", 32'(ifc.id_valid), 32'h0);
        chk("t3_req", 32'(ifc.imem_req), 32'h1);
        chk("t3_addr", 32'(ifc.imem_addr), 32'h40);
        ifc.id_ready = 1'b1;
        wait_valid("t3_timeout");
        chk("t3_pc", 32'(ifc.id_pc), 32'h40);
        chk("t3_instr", ifc.id_instr, 32'h104AC321);

        // 4: unaligned redirect coinciding with a pop, then a held redirect
        repeat (3) step();
        chk("t4_pre_valid", 32'(ifc.id_valid), 32'h1);
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 9'h043;
        step();
        ifc.redirect = 1'b0;
        #1;
        chk("t4_empty", 32'(ifc.fq_count), 32'h0);
        chk("t4_valid0", 32'(ifc.id_valid), 32'h0);
        chk("t4_addr", 32'(ifc.imem_addr), 32'h40);
        wait_valid("t4_timeout");
        chk("t4_pc", 32'(ifc.id_pc), 32'h40);
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 9'h080;
        #1;
        chk("t4_hold_req0", 32'(ifc.imem_req), 32'h0);
        step();
        ifc.redirect_pc = 9'h084;
        #1;
        chk("t4_hold_req1", 32'(ifc.imem_req), 32'h0);
        step();
        ifc.redirect_pc = 9'h100;
        step();
        ifc.redirect = 1'b0;
        #1;
        chk("t4_hold_addr", 32'(ifc.imem_addr), 32'h100);
        wait_valid("t4_hold_timeout");
        chk("t4_hold_pc", 32'(ifc.id_pc), 32'h100);
        chk("t4_hold_instr", ifc.id_instr, 32'h401AC351);

        // 5: PC wraps from 0x1FC to 0x000
        ifc.redirect    = 1'b1;
        ifc.redirect_pc = 9'h1F8;
        step();
        ifc.redirect = 1'b0;
        wait_valid("t5_timeout");
        begin
            logic [8:0]  wpc [4];
            logic [31:0] wins [4];
            wpc  = '{9'h1F8, 9'h1FC, 9'h000, 9'h004};
            wins = '{32'h7E24C38F, 32'h7F25C390, 32'h005AC311, 32'h015BC312};
            for (int i = 0; i < 4; i++) begin
                chk("t5_valid", 32'(ifc.id_valid), 32'h1);
                chk("t5_pc", 32'(ifc.id_pc), 32'(wpc[i]));
                chk("t5_instr", ifc.id_instr, wins[i]);
                step();
            end
        end

        // 6: asynchronous reset mid-stream
        repeat (2) step();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_valid", 32'(ifc.id_valid), 32'h0);
        chk("t6_instr", ifc.id_instr, 32'h0);
        chk("t6_pc", 32'(ifc.id_pc), 32'h0);
        chk("t6_count", 32'(ifc.fq_count), 32'h0);
        chk("t6_req", 32'(ifc.imem_req), 32'h0);
        repeat (2) @(posedge clka);
        #1;
        rst = 1'b0;
        #1;
        chk("t6_addr", 32'(ifc.imem_addr), 32'(RESET_PC));
        chk("t6_req_resume", 32'(ifc.imem_req), 32'h1);
        wait_valid("t6_timeout");
        chk("t6_first_pc", 32'(ifc.id_pc), 32'h0);
        chk("t6_first_instr", ifc.id_instr, 32'h005AC311);
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
